// File: rtl/ps2_led_ctrl_pkg.sv
// Shared PS/2 definitions for the LED sequencer and the scan-code decoder.
//   PS2_CMD_SET_LEDS : host command that selects the LED mask update
//   PS2_ACK          : device acknowledge
//   PS2_RESEND       : device request to retransmit the last byte
//   PS2_BREAK        : break prefix, used by the scan-code decoder
//   state_t          : LED sequencer states
package ps2_led_ctrl_pkg;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_ACK          = 8'hFA;
  localparam logic [7:0] PS2_RESEND       = 8'hFE;
  localparam logic [7:0] PS2_BREAK        = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_CMD,
    ST_ACK_CMD,
    ST_TX_ARG,
    ST_ACK_ARG
  } state_t;

endpackage

// File: rtl/ps2_ack_timer.sv
// ACK wait timer: counts enabled cycles from a clear and flags terminal count.
// The count saturates at TIMEOUT_CYCLES-1 rather than wrapping.
//   clk    : system clock
//   i_sclr : synchronous active-high reset
//   i_clr  : restart the count from zero
//   i_en   : advance the count this cycle
//   o_tc   : count has reached TIMEOUT_CYCLES-1
module ps2_ack_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic i_sclr,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] TC = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (i_sclr || i_clr) begin
      cnt <= '0;
    end else if (i_en && (cnt != TC)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign o_tc = (cnt == TC);

endmodule

// File: rtl/ps2_led_ctrl.sv
// Host-side PS/2 "set LEDs" sequencer: sends ED, waits for FA, sends the
// LED mask byte, waits for FA. FE or an ACK timeout retransmits the current
// byte up to MAX_RETRY times, after which the transaction is abandoned and
// o_err is set. ACK/RESEND bytes belonging to the transaction are consumed;
// every other received byte is forwarded to the decoder with zero latency.
//   clk, i_sclr          : clock, synchronous active-high reset
//   i_leds_en, i_leds    : LED update request and mask {caps,num,scroll}
//   i_byte_en, i_byte    : received byte from the PS/2 receiver
//   i_tx_done            : transmitter finished the current byte
//   o_tx_en, o_tx_byte   : transmit request and byte (held until next request)
//   o_byte_en, o_byte    : forwarded received byte to the decoder
//   o_busy               : transaction in progress
//   o_err                : sticky, last transaction abandoned
module ps2_led_ctrl
  import ps2_led_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_leds_en,
  input  logic [2:0] i_leds,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  input  logic       i_tx_done,
  output logic       o_tx_en,
  output logic [7:0] o_tx_byte,
  output logic       o_byte_en,
  output logic [7:0] o_byte,
  output logic       o_busy,
  output logic       o_err
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  state_t        state;
  logic [2:0]    mask;
  logic          pend;
  logic [2:0]    pend_mask;
  logic [RW-1:0] retry;

  logic in_ack;
  logic in_tx;
  logic is_ack;
  logic is_resend;
  logic consumed;
  logic tmr_tc;

  always_comb begin
    in_ack    = (state == ST_ACK_CMD) || (state == ST_ACK_ARG);
    in_tx     = (state == ST_TX_CMD)  || (state == ST_TX_ARG);
    is_ack    = i_byte_en && (i_byte == PS2_ACK);
    is_resend = i_byte_en && (i_byte == PS2_RESEND);
    consumed  = in_ack && (is_ack || is_resend);
  end

  assign o_byte_en = i_byte_en & ~consumed;
  assign o_byte    = i_byte;

  ps2_ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .i_sclr(i_sclr),
    .i_clr (in_tx && i_tx_done),
    .i_en  (in_ack),
    .o_tc  (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state     <= ST_IDLE;
      o_tx_en   <= 1'b0;
      o_tx_byte <= 8'h00;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
      mask      <= '0;
      pend      <= 1'b0;
      pend_mask <= '0;
      retry     <= '0;
    end else begin
      o_tx_en <= 1'b0;

      // Requests arriving mid-transaction are queued; the latest one wins.
      if (i_leds_en && (state != ST_IDLE)) begin
        pend      <= 1'b1;
        pend_mask <= i_leds;
      end

      case (state)
        ST_IDLE: begin
          if (i_leds_en || pend) begin
            mask      <= i_leds_en ? i_leds : pend_mask;
            pend      <= 1'b0;
            o_err     <= 1'b0;
            retry     <= '0;
            state     <= ST_TX_CMD;
            o_tx_en   <= 1'b1;
            o_tx_byte <= PS2_CMD_SET_LEDS;
            o_busy    <= 1'b1;
          end
        end

        ST_TX_CMD: if (i_tx_done) state <= ST_ACK_CMD;
        ST_TX_ARG: if (i_tx_done) state <= ST_ACK_ARG;

        ST_ACK_CMD, ST_ACK_ARG: begin
          // An ACK in the same cycle as the timeout takes precedence.
          if (is_ack) begin
            if (state == ST_ACK_CMD) begin
              state     <= ST_TX_ARG;
              o_tx_en   <= 1'b1;
              o_tx_byte <= {5'b00000, mask};
              retry     <= '0;
            end else begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
          end else if (is_resend || tmr_tc) begin
            if (retry < RETRY_LIM) begin
              // o_tx_byte still holds the byte being retried.
              retry   <= retry + RW'(1);
              state   <= (state == ST_ACK_CMD) ? ST_TX_CMD : ST_TX_ARG;
              o_tx_en <= 1'b1;
            end else begin
              o_err  <= 1'b1;
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_led_ctrl.sv
// Directed self-checking bench for ps2_led_ctrl (TIMEOUT_CYCLES=16, MAX_RETRY=3).
module tb_ps2_led_ctrl;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_leds_en = 1'b0;
  logic [2:0] i_leds = '0;
  logic       i_byte_en = 1'b0;
  logic [7:0] i_byte = '0;
  logic       i_tx_done = 1'b0;
  logic       o_tx_en;
  logic [7:0] o_tx_byte;
  logic       o_byte_en;
  logic [7:0] o_byte;
  logic       o_busy;
  logic       o_err;

  int n_checks = 0;
  int n_pass   = 0;
  int tx_cnt   = 0;
  int tx_base;
  logic fwd;

  ps2_led_ctrl #(
    .TIMEOUT_CYCLES(16),
    .MAX_RETRY     (3)
  ) dut (
    .clk      (clk),
    .i_sclr   (i_sclr),
    .i_leds_en(i_leds_en),
    .i_leds   (i_leds),
    .i_byte_en(i_byte_en),
    .i_byte   (i_byte),
    .i_tx_done(i_tx_done),
    .o_tx_en  (o_tx_en),
    .o_tx_byte(o_tx_byte),
    .o_byte_en(o_byte_en),
    .o_byte   (o_byte),
    .o_busy   (o_busy),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  // Each o_tx_en pulse lasts one cycle, so a negedge sample counts it once.
  always @(negedge clk) if (o_tx_en) tx_cnt = tx_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_leds(input logic [2:0] m);
    i_leds_en = 1'b1;
    i_leds    = m;
    step();
    i_leds_en = 1'b0;
  endtask

  task automatic tx_done();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  // Presents a byte for one cycle and reports whether it was forwarded.
  task automatic send_byte(input logic [7:0] b, output logic f);
    i_byte_en = 1'b1;
    i_byte    = b;
    #1;
    f = o_byte_en;
    check("o_byte_passthru", {24'h0, o_byte}, {24'h0, b});
    step();
    i_byte_en = 1'b0;
  endtask

  initial begin
    // Reset
    step();
    step();
    i_sclr = 1'b0;
    check("rst_busy", o_busy, 0);
    check("rst_tx_en", o_tx_en, 0);
    check("rst_tx_byte", o_tx_byte, 8'h00);
    check("rst_err", o_err, 0);

    // Happy path
    tx_base = tx_cnt;
    pulse_leds(3'b101);
    check("hp_tx_en_ed", o_tx_en, 1);
    check("hp_tx_byte_ed", o_tx_byte, 8'hED);
    check("hp_busy", o_busy, 1);
    step();
    check("hp_tx_en_single", o_tx_en, 0);
    tx_done();
    send_byte(8'hFA, fwd);
    check("hp_fa1_consumed", fwd, 0);
    check("hp_tx_en_arg", o_tx_en, 1);
    check("hp_tx_byte_arg", o_tx_byte, 8'h05);
    tx_done();
    send_byte(8'hFA, fwd);
    check("hp_fa2_consumed", fwd, 0);
    check("hp_idle", o_busy, 0);
    check("hp_err", o_err, 0);
    check("hp_tx_count", tx_cnt - tx_base, 2);

    // Resend
    tx_base = tx_cnt;
    pulse_leds(3'b101);
    tx_done();
    send_byte(8'hFE, fwd);
    check("rs_fe_consumed", fwd, 0);
    check("rs_tx_en_re", o_tx_en, 1);
    check("rs_tx_byte_re", o_tx_byte, 8'hED);
    tx_done();
    send_byte(8'hFA, fwd);
    check("rs_tx_byte_arg", o_tx_byte, 8'h05);
    tx_done();
    send_byte(8'hFA, fwd);
    check("rs_idle", o_busy, 0);
    check("rs_tx_count", tx_cnt - tx_base, 3);

    // Timeout exhaustion: 16 cycles in ACK before each retransmission
    tx_base = tx_cnt;
    pulse_leds(3'b011);
    for (int i = 0; i < 4; i++) begin
      tx_done();
      for (int k = 0; k < 15; k++) step();
      check("to_wait_no_tx", o_tx_en, 0);
      check("to_wait_busy", o_busy, 1);
      step();
      if (i < 3) begin
        check("to_retx_en", o_tx_en, 1);
        check("to_retx_byte", o_tx_byte, 8'hED);
      end else begin
        check("to_final_tx_en", o_tx_en, 0);
        check("to_final_busy", o_busy, 0);
        check("to_final_err", o_err, 1);
      end
    end
    step();
    step();
    check("to_tx_count", tx_cnt - tx_base, 4);

    // Passthrough in ACK_CMD and in IDLE; error clears on new transaction
    pulse_leds(3'b110);
    check("pt_err_cleared", o_err, 0);
    tx_done();
    send_byte(8'h1C, fwd);
    check("pt_scan_fwd", fwd, 1);
    check("pt_still_busy", o_busy, 1);
    check("pt_no_tx", o_tx_en, 0);
    send_byte(8'hFA, fwd);
    check("pt_fa_consumed", fwd, 0);
    check("pt_tx_byte_arg", o_tx_byte, 8'h06);
    send_byte(8'hFE, fwd);
    check("pt_fe_in_tx_fwd", fwd, 1);
    check("pt_fe_in_tx_no_tx", o_tx_en, 0);
    tx_done();
    send_byte(8'hFA, fwd);
    check("pt_idle", o_busy, 0);
    send_byte(8'hFA, fwd);
    check("pt_fa_idle_fwd", fwd, 1);

    // Queued request: last request while busy wins
    tx_base = tx_cnt;
    pulse_leds(3'b100);
    pulse_leds(3'b001);
    tx_done();
    pulse_leds(3'b010);
    send_byte(8'hFA, fwd);
    check("q_tx_byte_arg1", o_tx_byte, 8'h04);
    tx_done();
    send_byte(8'hFA, fwd);
    check("q_idle_gap", o_busy, 0);
    check("q_idle_gap_tx", o_tx_en, 0);
    step();
    check("q_restart_en", o_tx_en, 1);
    check("q_restart_byte", o_tx_byte, 8'hED);
    tx_done();
    send_byte(8'hFA, fwd);
    check("q_tx_byte_arg2", o_tx_byte, 8'h02);
    tx_done();
    send_byte(8'hFA, fwd);
    step();
    step();
    check("q_final_idle", o_busy, 0);
    check("q_tx_count", tx_cnt - tx_base, 4);

    // Reset in TX_ARG with a queued request
    pulse_leds(3'b101);
    tx_done();
    send_byte(8'hFA, fwd);
    pulse_leds(3'b011);
    check("mr_busy_pre", o_busy, 1);
    i_sclr = 1'b1;
    step();
    i_sclr = 1'b0;
    check("mr_busy", o_busy, 0);
    check("mr_tx_en", o_tx_en, 0);
    check("mr_tx_byte", o_tx_byte, 8'h00);
    check("mr_err", o_err, 0);
    tx_base = tx_cnt;
    for (int k = 0; k < 4; k++) step();
    check("mr_no_pending_tx", tx_cnt - tx_base, 0);
    check("mr_still_idle", o_busy, 0);
    send_byte(8'hFA, fwd);
    check("mr_fa_fwd", fwd, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
